// File: rtl/mem_request_scheduler_pkg.sv
// mem_request_scheduler_pkg: request payload type shared by the scheduler and its requesters
// Exports mem_request_t (address, read/write flag, requester tag).
package ctrl_signal_types;
  typedef struct packed {
    logic [31:0] addr;
    logic        is_write;
    logic [6:0]  tag;
  } mem_request_t;
endpackage

// File: rtl/mem_request_scheduler_priority_arbiter.sv
// priority_arbiter: combinational one-hot fixed-priority arbiter, lowest index wins
// Ports: req [N-1:0] request vector in, grant [N-1:0] one-hot grant out (zero when req is zero).
module priority_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);
  // Two's-complement trick isolates the lowest set bit.
  assign grant = req & (~req + N'(1));
endmodule

// File: rtl/mem_request_scheduler.sv
// mem_request_scheduler: fixed-priority N:1 request scheduler with a one-entry output register
// Ports: clk, reset_n (async active-low); in_valid/in_ready/in_request per requester port;
// out_valid/out_ready/out_request/out_port toward the memory pipeline.
// Optional starvation guard enabled by defining MEM_SCHED_STARVATION_GUARD_EN.
module mem_request_scheduler
  import ctrl_signal_types::*;
#(
  parameter int NUM_INPUT_PORT = 4,
  parameter int STARVE_LIMIT   = 8
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [NUM_INPUT_PORT-1:0]         in_valid,
  output logic [NUM_INPUT_PORT-1:0]         in_ready,
  input  mem_request_t                      in_request [NUM_INPUT_PORT],
  output logic                              out_valid,
  input  logic                              out_ready,
  output mem_request_t                      out_request,
  output logic [$clog2(NUM_INPUT_PORT)-1:0] out_port
);
  localparam int N  = NUM_INPUT_PORT;
  localparam int PW = $clog2(N);
  if (N < 2 || STARVE_LIMIT < 1) begin : g_bad_cfg
  end
  logic              accept;
  logic [N-1:0]      g_norm;
  logic [N-1:0]      g;
  mem_request_t      req_sel;
  logic [PW-1:0]     port_sel;
  // Pass-through drain: a held request may be replaced in the cycle it leaves.
  assign accept = ~out_valid | out_ready;
  priority_arbiter #(.N(N)) u_arb_norm (.req(in_valid), .grant(g_norm));
`ifdef MEM_SCHED_STARVATION_GUARD_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  logic [CW-1:0] wait_cnt [N];
  logic [N-1:0]  starved;
  logic [N-1:0]  g_starv;
  always_comb begin
    starved = '0;
    for (int i = 0; i < N; i++) starved[i] = wait_cnt[i] == CW'(STARVE_LIMIT);
  end
  priority_arbiter #(.N(N)) u_arb_starv (.req(starved & in_valid), .grant(g_starv));
  assign g = |(starved & in_valid) ? g_starv : g_norm;
  // Downstream stalls (accept low) hold the counters so they do not count as starvation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) wait_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++)
        if (!in_valid[i] || in_ready[i]) wait_cnt[i] <= '0;
        else if (accept && wait_cnt[i] != CW'(STARVE_LIMIT)) wait_cnt[i] <= wait_cnt[i] + CW'(1);
    end
  end
`else
  assign g = g_norm;
`endif
  assign in_ready = reset_n ? (g & {N{accept}}) : '0;
  always_comb begin
    req_sel  = '0;
    port_sel = '0;
    for (int i = 0; i < N; i++) begin
      req_sel = mem_request_t'(req_sel | (in_request[i] & {$bits(mem_request_t){g[i]}}));
      if (g[i]) port_sel = PW'(i);
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid   <= 1'b0;
      out_request <= '0;
      out_port    <= '0;
    end else if (|in_ready) begin
      out_valid   <= 1'b1;
      out_request <= req_sel;
      out_port    <= port_sel;
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mem_request_scheduler.sv
// tb_mem_request_scheduler: directed self-checking bench for mem_request_scheduler
module tb_mem_request_scheduler;
  import ctrl_signal_types::*;
  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [3:0]   in_valid = '0;
  logic [3:0]   in_ready;
  mem_request_t in_request [4];
  logic         out_valid;
  logic         out_ready = 1'b0;
  mem_request_t out_request;
  logic [1:0]   out_port;
  mem_request_t q [4][$];
  int           n_chk = 0;
  int           n_pass = 0;
  logic [3:0]   pv = '0;
  mem_request_t pr [4];
  mem_request_scheduler #(.NUM_INPUT_PORT(4), .STARVE_LIMIT(8)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_request(in_request), .out_valid(out_valid), .out_ready(out_ready),
    .out_request(out_request), .out_port(out_port)
  );
  always #5 clk = ~clk;
  // requester-side hold rule: a stalled request stays valid and stable
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (reset_n && pv[i])
        assert (in_valid[i] && in_request[i] == pr[i]) else $error("FAIL hold port %0d", i);
    pv <= reset_n ? (in_valid & ~in_ready) : '0;
    pr <= in_request;
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got %0h exp %0h", tag, got, exp);
  endtask
  function automatic mem_request_t mk(input int p, input int n);
    mem_request_t r;
    r.addr     = 32'h100 * p + n;
    r.is_write = (p % 2) == 1;
    r.tag      = 7'(p * 16 + n);
    return r;
  endfunction
  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      in_valid[i]   = q[i].size() != 0;
      in_request[i] = q[i].size() != 0 ? q[i][0] : '0;
    end
    #1;
  endtask
  task automatic push(input int p, input int cnt);
    for (int n = 0; n < cnt; n++) q[p].push_back(mk(p, n));
  endtask
  task automatic tick();
    logic [3:0] f;
    @(negedge clk);
    f = in_valid & in_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) if (f[i]) void'(q[i].pop_front());
    drive();
  endtask
  initial begin
    for (int i = 0; i < 4; i++) in_request[i] = '0;
    // reset with every port requesting
    for (int i = 0; i < 4; i++) push(i, 1);
    drive();
    tick();
    tick();
    chk("rst_in_ready", 64'(in_ready), 64'h0);
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_out_port", 64'(out_port), 64'h0);
    chk("rst_out_request", 64'(out_request), 64'h0);
    reset_n = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("rel_in_ready", 64'(in_ready), 64'h1);
    tick();
    chk("rel_out_valid", 64'(out_valid), 64'h1);
    chk("rel_out_request", 64'(out_request), 64'(mk(0, 0)));
    for (int p = 0; p < 4; p++) begin
      if (p != 0) tick();
      chk("rel_order", 64'(out_port), 64'(p));
    end
    tick();
    chk("rel_drain", 64'(out_valid), 64'h0);
    // priority: ports 1 and 3 requesting, port 1 always wins
    push(1, 5);
    push(3, 2);
    drive();
    chk("pri_in_ready", 64'(in_ready), 64'h2);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("pri_port", 64'(out_port), 64'h1);
      chk("pri_payload", 64'(out_request), 64'(mk(1, k)));
    end
    tick();
    chk("pri_port3", 64'(out_port), 64'h3);
    tick();
    tick();
    chk("pri_drain", 64'(out_valid), 64'h0);
    // backpressure
    out_ready = 1'b0;
    push(2, 2);
    drive();
    tick();
    chk("bp_load", 64'(out_request), 64'(mk(2, 0)));
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_valid", 64'(out_valid), 64'h1);
      chk("bp_payload", 64'(out_request), 64'(mk(2, 0)));
      chk("bp_in_ready", 64'(in_ready), 64'h0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(in_ready), 64'h4);
    tick();
    chk("bp_nobubble_valid", 64'(out_valid), 64'h1);
    chk("bp_nobubble_payload", 64'(out_request), 64'(mk(2, 1)));
    tick();
    chk("bp_drain", 64'(out_valid), 64'h0);
    // back-to-back from ports 0 and 2
    push(0, 3);
    push(2, 3);
    drive();
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("b2b_valid", 64'(out_valid), 64'h1);
      chk("b2b_port", 64'(out_port), k < 3 ? 64'h0 : 64'h2);
      chk("b2b_payload", 64'(out_request), 64'(k < 3 ? mk(0, k) : mk(2, k - 3)));
    end
    tick();
    chk("b2b_drain", 64'(out_valid), 64'h0);
    // starvation: port 0 hogs, port 3 waits
    push(0, 20);
    push(3, 1);
    drive();
    for (int t = 1; t <= 10; t++) begin
      tick();
`ifdef MEM_SCHED_STARVATION_GUARD_EN
      chk("starve_port", 64'(out_port), t == 9 ? 64'h3 : 64'h0);
`else
      chk("starve_port", 64'(out_port), 64'h0);
`endif
    end
`ifdef MEM_SCHED_STARVATION_GUARD_EN
    chk("starve_resume", 64'(out_request), 64'(mk(0, 8)));
`else
    chk("starve_resume", 64'(out_request), 64'(mk(0, 9)));
`endif
    // mid-operation asynchronous reset
    chk("mid_pre_valid", 64'(out_valid), 64'h1);
    reset_n = 1'b0;
    for (int i = 0; i < 4; i++) q[i].delete();
    #1;
    chk("mid_out_valid", 64'(out_valid), 64'h0);
    chk("mid_out_port", 64'(out_port), 64'h0);
    chk("mid_out_request", 64'(out_request), 64'h0);
    chk("mid_in_ready", 64'(in_ready), 64'h0);
`ifdef MEM_SCHED_STARVATION_GUARD_EN
    for (int i = 0; i < 4; i++) chk("mid_cnt", 64'(dut.wait_cnt[i]), 64'h0);
`endif
    drive();
    tick();
    reset_n = 1'b1;
    tick();
    chk("post_out_valid", 64'(out_valid), 64'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mem_request_scheduler.md
# mem_request_scheduler

Shares one downstream memory-request channel among `NUM_INPUT_PORT` requesters inside the page access counter. Each cycle it selects at most one pending request by fixed priority, with port 0 highest, and holds it in a one-entry output register. The block sits between the counter's request sources (lookup, writeback, migration) and the memory-facing pipeline. An optional starvation guard forces service of any port that has been stalled too long.

## Interface
- `NUM_INPUT_PORT`, default 4: number of requester ports; must be ≥2.
- `STARVE_LIMIT`, default 8: stalled cycles after which a port counts as starved; must be ≥1. Used only with the starvation guard.
- `clk` input 1: single clock; all state is on its rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `in_valid` input [NUM_INPUT_PORT]: per-port request valid.
- `in_ready` output [NUM_INPUT_PORT]: per-port accept; at most one bit is high per cycle.
- `in_request` input mem_request_t [NUM_INPUT_PORT]: per-port request payload.
- `out_valid` output 1: output register holds a request.
- `out_ready` input 1: downstream accepts the request.
- `out_request` output mem_request_t: registered payload.
- `out_port` output $clog2(NUM_INPUT_PORT): index of the port that sourced `out_request`.

## Operation
- Handshakes use valid/ready. Transfer occurs when both are high at a rising edge.
- Requester rule: once `in_valid[i]` is high, it stays high with `in_request[i]` stable until `in_ready[i]` is high. The bench asserts this; the RTL does not check it.
- `accept` = `~out_valid | out_ready`. This is the one-entry output register with pass-through drain.
- Grant vector `g` = fixed priority over `in_valid`: the lowest index wins. `in_ready` = `g & {N{accept}}`, forced to 0 while `reset_n` is low.
- On a transfer from port k: `out_request` <= `in_request[k]`, `out_port` <= k, `out_valid` <= 1.
- If `out_valid & out_ready` and no input transfer occurs: `out_valid` <= 0. Payload registers keep their old value.
- Simultaneous drain and load in the same cycle: the new request replaces the old one with no bubble.
- `out_valid` low, `out_ready` ignored: no state change.
- Reset mid-operation: the held request is discarded. The requester must re-present after reset.

## Timing
- Reset values: `out_valid` 0, `out_request` all-zero, `out_port` 0, all starvation counters 0, `in_ready` 0.
- Latency: 1 cycle from input handshake to `out_valid`.
- Throughput: 1 request per cycle while `out_ready` stays high.
- Backpressure: with `out_ready` low and `out_valid` high, `in_ready` is all-zero within the same cycle.
- There is no combinational path from `in_valid` to `out_valid`. There is a combinational path from `out_ready` and `in_valid` to `in_ready`.

## Configuration
- Macro: `MEM_SCHED_STARVATION_GUARD_EN`.
- With the macro defined:
  - Each port has a wait counter `wait_cnt[i]` of width $clog2(STARVE_LIMIT+1).
  - The counter increments, saturating at `STARVE_LIMIT`, when `in_valid[i] & ~in_ready[i]`.
  - The counter clears on a transfer or when `in_valid[i]` is low.
  - `starved[i]` = `wait_cnt[i] == STARVE_LIMIT`.
  - If any port is starved, the grant is fixed priority over `starved & in_valid`. Otherwise the normal grant applies.
  - Counters do not advance while `accept` is low. A downstream stall is not counted as starvation.
- Without the macro: pure fixed priority. No counters are instantiated, and `STARVE_LIMIT` is unused.

## Structure
- Package `ctrl_signal_types` holds `mem_request_t`. Add `MEM_SCHED_PORT_W_MAX` to the same package if port-index typedefs are shared with the requesters.
- Sub-module: `priority_arbiter` (combinational, one-hot, lowest index wins).
  - Instantiate it once for the normal grant.
  - Instantiate a second copy over `starved & in_valid` under the macro.
- Ports are muxed by a one-hot AND-OR of `in_request` using the final grant. An encoder of that grant drives `out_port`.

## Test plan
- Reset check: hold `reset_n` low with all `in_valid`=1 → `in_ready`=0000 and `out_valid`=0. One cycle after release with `out_ready`=1 → `in_ready`=0001, then `out_port`=0.
- Priority: `in_valid`=1010 with `out_ready`=1 → port 1 served every cycle and port 3 never served; `out_port`=1 each cycle after the first.
- Backpressure: load a request from port 2, then hold `out_ready`=0 for 5 cycles → `out_valid`=1 with a stable payload and `in_ready`=0000. On release, the drain and the next load happen in the same cycle with no bubble.
- Back-to-back: ports 0 and 2 each present 3 requests, `out_ready`=1 → 6 consecutive output cycles, port 0's three first, payload order preserved.
- Starvation (macro on, N=4, STARVE_LIMIT=8): hold port 0 continuously valid and port 3 valid → port 3 granted on the 9th cycle of waiting, then port 0 resumes. Macro off: port 3 is never granted.
- Mid-operation reset: assert `reset_n` low while `out_valid`=1 → `out_valid` drops immediately (asynchronous), and all counters read 0 after release.
